// File: rtl/gcd_host.sv
// Synthesizable initiator for one gcd core: accepts operand pairs, sequences the
// core's load/run phases under a timeout, and returns the result on a valid/ready channel.
module gcd_host #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned LOAD_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             core_rst,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic [WIDTH-1:0] core_ret,
  input  logic             core_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_ret,
  output logic             out_timeout
);

  // One shared counter; it never needs to exceed the larger of the two limits minus one.
  localparam int unsigned CNT_MAX = (TIMEOUT > LOAD_CYCLES) ? TIMEOUT : LOAD_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] core_a_d, core_b_d, out_ret_d;
  logic             out_timeout_d;

  // Next-state and next-output decode.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    core_a_d      = core_a;
    core_b_d      = core_b;
    out_ret_d     = out_ret;
    out_timeout_d = out_timeout;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          core_a_d = in_a;
          core_b_d = in_b;
          if ((in_a == '0) || (in_b == '0)) begin
            out_ret_d     = in_a | in_b;
            out_timeout_d = 1'b0;
            state_d       = RESP;
          end else begin
            cnt_d   = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(LOAD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt + CW'(1);
        if (core_done) begin
          out_ret_d     = core_ret;
          out_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          out_ret_d     = '0;
          out_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and core-control outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready    <= 1'b0;
      core_rst    <= 1'b1;
      core_a      <= '0;
      core_b      <= '0;
      out_valid   <= 1'b0;
      out_ret     <= '0;
      out_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      in_ready    <= (state_d == IDLE);
      core_rst    <= (state_d != RUN);
      core_a      <= core_a_d;
      core_b      <= core_b_d;
      out_valid   <= (state_d == RESP);
      out_ret     <= out_ret_d;
      out_timeout <= out_timeout_d;
    end
  end

endmodule
